player_mover: RTL and testbench

- Parametrised successor to the player controller: moves an axis-aligned sprite box one STEP per move tick and rejects moves into wall tiles or past the screen edge.
- Collision data comes from a latency-tolerant tile-map read port, not a full map bus, so the map can live in block RAM.
- Sits between the debounced button inputs and the VGA sprite renderer and level logic.

---
 rtl/player_pkg.sv | 32 +++
 rtl/player_probe_addr.sv | 121 ++++++++++++
 rtl/player_mover.sv | 179 +++++++++++++++++
 tb/tb_player_mover.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and defaults for the player sprite mover.
package player_pkg;

  localparam int unsigned DefScreenW = 640;
  localparam int unsigned DefScreenH = 480;
  localparam int unsigned DefTileLog2 = 3;

  // Evaluation FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StProbeA,
    StWaitA,
    StProbeB,
    StWaitB,
    StDone
  } state_e;

  // Latched move direction.
  typedef enum logic [2:0] {
    DirNone,
    DirUp,
    DirDown,
    DirLeft,
    DirRight
  } dir_t;

  // Width of a tile index along an axis of px pixels.
  function automatic int unsigned tile_w(int unsigned px, int unsigned lg);
    return $clog2(px >> lg);
  endfunction

endpackage

// File: rtl/player_probe_addr.sv
// Candidate-box and probe-corner to tile mapping for player_mover.
// PLAYER_WRAP_EN: edge crossings wrap to the fully wrapped position instead of
// being flagged out_of_screen.
module player_probe_addr
  import player_pkg::*;
#(
  parameter int unsigned SCREEN_W  = DefScreenW,
  parameter int unsigned SCREEN_H  = DefScreenH,
  parameter int unsigned TILE_LOG2 = DefTileLog2,
  parameter int unsigned SPRITE    = 8,
  parameter int unsigned STEP      = 2
) (
  input  dir_t                                     dir_i,
  input  logic [$clog2(SCREEN_W)-1:0]              left_i,
  input  logic [$clog2(SCREEN_W)-1:0]              right_i,
  input  logic [$clog2(SCREEN_H)-1:0]              top_i,
  input  logic [$clog2(SCREEN_H)-1:0]              bot_i,
  input  logic                                     probe_b_i,
  output logic [tile_w(SCREEN_H, TILE_LOG2)-1:0]   row_o,
  output logic [tile_w(SCREEN_W, TILE_LOG2)-1:0]   col_o,
  output logic                                     same_tile_o,
  output logic                                     out_of_screen_o,
  output logic [$clog2(SCREEN_W)-1:0]              cand_left_o,
  output logic [$clog2(SCREEN_H)-1:0]              cand_top_o
);

  localparam int unsigned XW = $clog2(SCREEN_W);
  localparam int unsigned YW = $clog2(SCREEN_H);
  localparam int unsigned CW = tile_w(SCREEN_W, TILE_LOG2);
  localparam int unsigned RW = tile_w(SCREEN_H, TILE_LOG2);

  localparam logic [XW:0] StepX = (XW + 1)'(STEP);
  localparam logic [YW:0] StepY = (YW + 1)'(STEP);
  localparam logic [XW:0] SprX  = (XW + 1)'(SPRITE - 1);
  localparam logic [YW:0] SprY  = (YW + 1)'(SPRITE - 1);
  localparam logic [XW:0] LimX  = (XW + 1)'(SCREEN_W);
  localparam logic [YW:0] LimY  = (YW + 1)'(SCREEN_H);

  logic [XW:0]   cl;
  logic [YW:0]   ct;
  logic [XW-1:0] cand_right, px;
  logic [YW-1:0] cand_bot, py;

  // Shift the box one bit wider than the bounds so underflow shows in the MSB.
  always_comb begin
    cl = {1'b0, left_i};
    ct = {1'b0, top_i};
    out_of_screen_o = 1'b0;
    case (dir_i)
      DirUp: begin
        ct = {1'b0, top_i} - StepY;
        if (ct[YW]) begin
`ifdef PLAYER_WRAP_EN
          ct = (YW + 1)'(SCREEN_H - SPRITE);
`else
          out_of_screen_o = 1'b1;
`endif
        end
      end
      DirDown: begin
        ct = {1'b0, top_i} + StepY;
        if (ct + SprY >= LimY) begin
`ifdef PLAYER_WRAP_EN
          ct = '0;
`else
          out_of_screen_o = 1'b1;
`endif
        end
      end
      DirLeft: begin
        cl = {1'b0, left_i} - StepX;
        if (cl[XW]) begin
`ifdef PLAYER_WRAP_EN
          cl = (XW + 1)'(SCREEN_W - SPRITE);
`else
          out_of_screen_o = 1'b1;
`endif
        end
      end
      DirRight: begin
        cl = {1'b0, left_i} + StepX;
        if (cl + SprX >= LimX) begin
`ifdef PLAYER_WRAP_EN
          cl = '0;
`else
          out_of_screen_o = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign cand_left_o = cl[XW-1:0];
  assign cand_top_o  = ct[YW-1:0];
  assign cand_right  = cand_left_o + XW'(SPRITE - 1);
  assign cand_bot    = cand_top_o + YW'(SPRITE - 1);

  // Probe A takes the left/top end of the leading edge, probe B the right/bottom end.
  always_comb begin
    px = probe_b_i ? right_i : left_i;
    py = probe_b_i ? bot_i : top_i;
    same_tile_o = ((left_i >> TILE_LOG2) == (right_i >> TILE_LOG2));
    case (dir_i)
      DirUp:   py = cand_top_o;
      DirDown: py = cand_bot;
      DirLeft: begin
        px = cand_left_o;
        same_tile_o = ((top_i >> TILE_LOG2) == (bot_i >> TILE_LOG2));
      end
      DirRight: begin
        px = cand_right;
        same_tile_o = ((top_i >> TILE_LOG2) == (bot_i >> TILE_LOG2));
      end
      default: ;
    endcase
    row_o = RW'(py >> TILE_LOG2);
    col_o = CW'(px >> TILE_LOG2);
  end

endmodule

// File: rtl/player_mover.sv
// Sprite box mover with tile-map collision probing over a latency-tolerant read port.
// PLAYER_WRAP_EN: screen-edge crossings wrap around instead of being blocked.
module player_mover
  import player_pkg::*;
#(
  parameter int unsigned SCREEN_W  = DefScreenW,
  parameter int unsigned SCREEN_H  = DefScreenH,
  parameter int unsigned TILE_LOG2 = DefTileLog2,
  parameter int unsigned SPRITE    = 8,
  parameter int unsigned STEP      = 2,
  parameter int unsigned SPAWN_X   = 0,
  parameter int unsigned SPAWN_Y   = 0,
  parameter int unsigned MAP_LAT   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   up,
  input  logic                                   down,
  input  logic                                   left,
  input  logic                                   right,
  input  logic                                   move_tick,
  output logic                                   map_rd_en,
  output logic [tile_w(SCREEN_H, TILE_LOG2)-1:0] map_row,
  output logic [tile_w(SCREEN_W, TILE_LOG2)-1:0] map_col,
  input  logic                                   map_wall,
  output logic [$clog2(SCREEN_H)-1:0]            top_bound,
  output logic [$clog2(SCREEN_H)-1:0]            bot_bound,
  output logic [$clog2(SCREEN_W)-1:0]            left_bound,
  output logic [$clog2(SCREEN_W)-1:0]            right_bound,
  output logic                                   busy,
  output logic                                   moved,
  output logic                                   blocked
);

  localparam int unsigned XW   = $clog2(SCREEN_W);
  localparam int unsigned YW   = $clog2(SCREEN_H);
  localparam int unsigned CntW = $clog2(MAP_LAT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAP_LAT - 1);

  state_e            state_q, state_d;
  dir_t              dir_q, dir_d, dir_sel, calc_dir;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ok_q, ok_d;
  logic [XW-1:0]     left_q, left_d, right_q, right_d, cand_left;
  logic [YW-1:0]     top_q, top_d, bot_q, bot_d, cand_top;
  logic              probe_b, same_tile, out_of_screen;

  assign dir_sel = up    ? DirUp    :
                   down  ? DirDown  :
                   left  ? DirLeft  :
                   right ? DirRight : DirNone;

  // While idle the candidate follows the live buttons so the edge check is ready on the tick.
  assign calc_dir = (state_q == StIdle) ? dir_sel : dir_q;
  assign probe_b  = (state_q == StProbeB) || (state_q == StWaitB);

  player_probe_addr #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .TILE_LOG2 (TILE_LOG2),
    .SPRITE    (SPRITE),
    .STEP      (STEP)
  ) u_probe_addr (
    .dir_i           (calc_dir),
    .left_i          (left_q),
    .right_i         (right_q),
    .top_i           (top_q),
    .bot_i           (bot_q),
    .probe_b_i       (probe_b),
    .row_o           (map_row),
    .col_o           (map_col),
    .same_tile_o     (same_tile),
    .out_of_screen_o (out_of_screen),
    .cand_left_o     (cand_left),
    .cand_top_o      (cand_top)
  );

  // State, latched direction, wait counter, verdict and bounds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dir_q   <= DirNone;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      left_q  <= XW'(SPAWN_X);
      right_q <= XW'(SPAWN_X + SPRITE - 1);
      top_q   <= YW'(SPAWN_Y);
      bot_q   <= YW'(SPAWN_Y + SPRITE - 1);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      left_q  <= left_d;
      right_q <= right_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
    end
  end

  // Next-state: probe sequencing and commit of the candidate box.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    left_d  = left_q;
    right_d = right_q;
    top_d   = top_q;
    bot_d   = bot_q;
    unique case (state_q)
      StIdle: begin
        if (move_tick && (dir_sel != DirNone)) begin
          dir_d = dir_sel;
          if (out_of_screen) begin
            ok_d    = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StProbeA;
          end
        end
      end
      StProbeA: begin
        cnt_d   = '0;
        state_d = StWaitA;
      end
      StWaitA: begin
        if (cnt_q == LastCnt) begin
          if (map_wall) begin
            ok_d    = 1'b0;
            state_d = StDone;
          end else if (same_tile) begin
            ok_d    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StProbeB;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StProbeB: begin
        cnt_d   = '0;
        state_d = StWaitB;
      end
      StWaitB: begin
        if (cnt_q == LastCnt) begin
          ok_d    = !map_wall;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (ok_q) begin
          left_d  = cand_left;
          right_d = cand_left + XW'(SPRITE - 1);
          top_d   = cand_top;
          bot_d   = cand_top + YW'(SPRITE - 1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy        = (state_q != StIdle);
    map_rd_en   = (state_q == StProbeA) || (state_q == StProbeB);
    moved       = (state_q == StDone) && ok_q;
    blocked     = (state_q == StDone) && !ok_q;
    left_bound  = left_q;
    right_bound = right_q;
    top_bound   = top_q;
    bot_bound   = bot_q;
  end

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: vector table on a MAP_LAT=1 instance plus
// hand sequences for latency, dropped ticks and mid-evaluation reset on a MAP_LAT=3 one.
module tb_player_mover;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Instance A: defaults, MAP_LAT = 1.
  logic       a_up = 0, a_down = 0, a_left = 0, a_right = 0, a_tick = 0;
  logic       a_rd_en, a_map_wall, a_busy, a_moved, a_blocked;
  logic [5:0] a_row;
  logic [6:0] a_col;
  logic [8:0] a_top, a_bot;
  logic [9:0] a_lb, a_rb;

  // Instance B: spawn (0,4) so a rightward move needs two probes; MAP_LAT = 3.
  logic       b_up = 0, b_down = 0, b_left = 0, b_right = 0, b_tick = 0;
  logic       b_rd_en, b_map_wall, b_busy, b_moved, b_blocked;
  logic [5:0] b_row;
  logic [6:0] b_col;
  logic [8:0] b_top, b_bot;
  logic [9:0] b_lb, b_rb;
  assign b_map_wall = 1'b0;

  player_mover u_dut_a (
    .clk(clk), .reset(rst_n), .up(a_up), .down(a_down), .left(a_left), .right(a_right),
    .move_tick(a_tick), .map_rd_en(a_rd_en), .map_row(a_row), .map_col(a_col),
    .map_wall(a_map_wall), .top_bound(a_top), .bot_bound(a_bot), .left_bound(a_lb),
    .right_bound(a_rb), .busy(a_busy), .moved(a_moved), .blocked(a_blocked)
  );

  player_mover #(.SPAWN_Y(4), .MAP_LAT(3)) u_dut_b (
    .clk(clk), .reset(rst_n), .up(b_up), .down(b_down), .left(b_left), .right(b_right),
    .move_tick(b_tick), .map_rd_en(b_rd_en), .map_row(b_row), .map_col(b_col),
    .map_wall(b_map_wall), .top_bound(b_top), .bot_bound(b_bot), .left_bound(b_lb),
    .right_bound(b_rb), .busy(b_busy), .moved(b_moved), .blocked(b_blocked)
  );

  // Tile map for A: one optional wall tile, answered exactly one cycle after the request.
  bit a_wall_on = 0;
  int a_wall_row = 0, a_wall_col = 0;
  bit p_v [0:1];
  int p_row [0:1];
  int p_col [0:1];
  always @(negedge clk) begin
    p_v[0]   <= a_rd_en;
    p_row[0] <= int'(a_row);
    p_col[0] <= int'(a_col);
    p_v[1]   <= p_v[0];
    p_row[1] <= p_row[0];
    p_col[1] <= p_col[0];
  end
  assign a_map_wall = p_v[1] && a_wall_on && (p_row[1] == a_wall_row) && (p_col[1] == a_wall_col);

  // Pulse and read monitors.
  int a_reads = 0, a_mv = 0, a_bk = 0, a_last_row = 0;
  int b_reads = 0, b_mv = 0, b_bk = 0, b_last_row = 0, b_last_col = 0;
  always @(negedge clk) begin
    if (a_rd_en) begin
      a_reads <= a_reads + 1;
      a_last_row <= int'(a_row);
    end
    if (a_moved) a_mv <= a_mv + 1;
    if (a_blocked) a_bk <= a_bk + 1;
    if (b_rd_en) begin
      b_reads <= b_reads + 1;
      b_last_row <= int'(b_row);
      b_last_col <= int'(b_col);
    end
    if (b_moved) b_mv <= b_mv + 1;
    if (b_blocked) b_bk <= b_bk + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit u, d, l, r;
    bit wall;
    int wrow, wcol;
    int e_left, e_top, e_mv, e_bk, e_rd, e_row;
  } vec_t;

  function automatic vec_t mk(bit u, bit d, bit l, bit r, bit wall, int wrow, int wcol,
                              int el, int et, int mv, int bk, int rd, int row);
    vec_t v;
    v.u = u; v.d = d; v.l = l; v.r = r;
    v.wall = wall; v.wrow = wrow; v.wcol = wcol;
    v.e_left = el; v.e_top = et; v.e_mv = mv; v.e_bk = bk; v.e_rd = rd; v.e_row = row;
    return v;
  endfunction

  task automatic apply_a(input vec_t v, input int idx);
    int mv0, bk0, rd0;
    bit done;
    a_up = v.u; a_down = v.d; a_left = v.l; a_right = v.r;
    a_wall_on = v.wall; a_wall_row = v.wrow; a_wall_col = v.wcol;
    @(negedge clk);
    #1;
    mv0 = a_mv; bk0 = a_bk; rd0 = a_reads;
    a_tick = 1'b1;
    @(negedge clk);
    a_tick = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (!a_busy) done = 1'b1;
      else @(negedge clk);
    end
    #1;
    check($sformatf("v%0d finished", idx), int'(done), 1);
    check($sformatf("v%0d left", idx), int'(a_lb), v.e_left);
    check($sformatf("v%0d right", idx), int'(a_rb), v.e_left + 7);
    check($sformatf("v%0d top", idx), int'(a_top), v.e_top);
    check($sformatf("v%0d bot", idx), int'(a_bot), v.e_top + 7);
    check($sformatf("v%0d moved", idx), a_mv - mv0, v.e_mv);
    check($sformatf("v%0d blocked", idx), a_bk - bk0, v.e_bk);
    check($sformatf("v%0d reads", idx), a_reads - rd0, v.e_rd);
    if (v.e_row >= 0) check($sformatf("v%0d probe row", idx), a_last_row, v.e_row);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [16];
    int moved_at, mv_cnt, mv0, bk0, rd0;

    //                u  d  l  r  wall r  c   left top mv bk rd row
    vecs[0]  = mk(0, 0, 0, 1, 1, 0, 1,   0,   0, 0, 1, 1, -1); // wall ahead
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0,   2,   0, 1, 0, 1, -1);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0, 0,   4,   0, 1, 0, 1, -1);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0,   6,   0, 1, 0, 1, -1);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0,   6,   2, 1, 0, 2, -1); // two column tiles
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, 0,   6,   4, 1, 0, 2, -1);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0,   4,   4, 1, 0, 2, -1); // two row tiles
    vecs[7]  = mk(0, 0, 0, 1, 1, 1, 1,   4,   4, 0, 1, 2, -1); // wall on probe B
    vecs[8]  = mk(1, 0, 1, 0, 0, 0, 0,   4,   2, 1, 0, 2, -1); // up beats left
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0,   4,   0, 1, 0, 2, -1);
`ifdef PLAYER_WRAP_EN
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0,   4, 472, 1, 0, 2, 59);
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 0,   2, 472, 1, 0, 1, -1);
    vecs[12] = mk(0, 0, 1, 0, 0, 0, 0,   0, 472, 1, 0, 1, -1);
    vecs[13] = mk(0, 0, 1, 0, 0, 0, 0, 632, 472, 1, 0, 1, -1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 632, 472, 0, 0, 0, -1); // tick, no button
    vecs[15] = mk(0, 1, 0, 1, 0, 0, 0, 632,   0, 1, 0, 1, -1); // down beats right
`else
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0,   4,   0, 0, 1, 0, -1); // top edge
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 0,   2,   0, 1, 0, 1, -1);
    vecs[12] = mk(0, 0, 1, 0, 0, 0, 0,   0,   0, 1, 0, 1, -1);
    vecs[13] = mk(0, 0, 1, 0, 0, 0, 0,   0,   0, 0, 1, 0, -1); // left edge
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, -1); // tick, no button
    vecs[15] = mk(0, 1, 0, 1, 0, 0, 0,   0,   2, 1, 0, 1, -1); // down beats right
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("a reset left", int'(a_lb), 0);
    check("a reset right", int'(a_rb), 7);
    check("a reset top", int'(a_top), 0);
    check("a reset bot", int'(a_bot), 7);
    check("a reset busy", int'(a_busy), 0);
    check("a reset rd_en", int'(a_rd_en), 0);
    check("a reset moved", int'(a_moved), 0);
    check("a reset blocked", int'(a_blocked), 0);
    check("b reset left", int'(b_lb), 0);
    check("b reset top", int'(b_top), 4);
    check("b reset bot", int'(b_bot), 11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) apply_a(vecs[i], i);

    // B: second tick two cycles into an evaluation is dropped; moved lands 2*(3+1)+1 cycles on.
    b_right = 1'b1;
    #1;
    mv0 = b_mv; bk0 = b_bk; rd0 = b_reads;
    moved_at = -1;
    mv_cnt = 0;
    b_tick = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) b_tick = 1'b0;
      if (n == 2) b_tick = 1'b1;
      if (n == 3) b_tick = 1'b0;
      if (b_moved) begin
        mv_cnt++;
        moved_at = n;
      end
    end
    #1;
    check("b moved count", mv_cnt, 1);
    check("b moved cycle", moved_at, 9);
    check("b monitor moved", b_mv - mv0, 1);
    check("b blocked", b_bk - bk0, 0);
    check("b reads", b_reads - rd0, 2);
    check("b probe row", b_last_row, 1);
    check("b probe col", b_last_col, 1);
    check("b left after", int'(b_lb), 2);
    check("b right after", int'(b_rb), 9);

    // B: reset asserted in WAIT_A aborts the move.
    @(negedge clk);
    b_tick = 1'b1;
    @(negedge clk);
    b_tick = 1'b0;
    @(negedge clk);
    check("b busy before reset", int'(b_busy), 1);
    rst_n = 1'b0;
    #1;
    check("b busy in reset", int'(b_busy), 0);
    check("b left in reset", int'(b_lb), 0);
    check("b top in reset", int'(b_top), 4);
    mv0 = b_mv; bk0 = b_bk;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("b moved after reset", b_mv - mv0, 0);
    check("b blocked after reset", b_bk - bk0, 0);
    check("b left after reset", int'(b_lb), 0);
    check("b busy after reset", int'(b_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
